mem_responder: RTL and testbench

Word-addressed data-memory responder that serves load/store requests from the multicycle CPU datapath over a req/ack handshake, replacing the fixed single-cycle memory when wait states are needed. It captures one request, inserts a programmable number of wait cycles, commits the write or fetches the read word from its internal array, and pulses `ack` for one cycle. It also flags misaligned and out-of-range addresses instead of accessing the array.

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed data memory behind a req/ack handshake with programmable wait states.
// Misaligned or out-of-range addresses are answered with err instead of touching the array.
//
// state | meaning
// IDLE  | waiting for req; captures wr/addr/wdata on the accepting edge
// WAIT  | counting down inserted wait cycles, inputs ignored
// RESP  | ack (and err) high for one cycle, always returns to IDLE
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
    $error("mem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       state;
  logic [3:0]  count;
  logic        capWr;
  logic [31:0] capAddr;
  logic [31:0] capWdata;
  logic [31:0] mem [DEPTH];

  logic                 accWr;
  logic [31:0]          accAddr;
  logic [31:0]          accWdata;
  logic                 accBad;
  logic [ADDR_BITS-1:0] accIndex;
  logic                 enterResp;

  // With no wait states the commit happens on the capture edge itself, so the
  // access is taken straight from the inputs rather than the capture registers.
  always_comb begin
    accWr    = capWr;
    accAddr  = capAddr;
    accWdata = capWdata;
    if (state == IDLE) begin
      accWr    = wr;
      accAddr  = addr;
      accWdata = wdata;
    end
  end

  assign accBad    = (accAddr[1:0] != 2'b00) || ((accAddr >> (ADDR_BITS + 2)) != 32'd0);
  assign accIndex  = accAddr[ADDR_BITS+1:2];
  assign enterResp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (count == 4'd1));

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (enterResp && accWr && !accBad && !reset) begin
      mem[accIndex] <= accWdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      capWr    <= 1'b0;
      capAddr  <= 32'd0;
      capWdata <= 32'd0;
      rdata    <= 32'd0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            capWr    <= wr;
            capAddr  <= addr;
            capWdata <= wdata;
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (enterResp) begin
        ack <= 1'b1;
        err <= accBad;
        if (!accWr) begin
          rdata <= accBad ? 32'd0 : mem[accIndex];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (2, 0 and 15 wait cycles),
// expected responses queued at drive time and compared when ack appears.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  reqV;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdataV [3];
  logic [2:0]  ackV;
  logic [2:0]  errV;
  logic [2:0]  busyV;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } respT;

  respT        sb [$];
  logic [31:0] modelMem [int];
  logic [31:0] expRd [3];

  always #5 clock = ~clock;

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut0 (
    .clock(clock), .reset(reset), .req(reqV[0]), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdataV[0]), .ack(ackV[0]), .err(errV[0]), .busy(busyV[0])
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset), .req(reqV[1]), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdataV[1]), .ack(ackV[1]), .err(errV[1]), .busy(busyV[1])
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(15)) dut2 (
    .clock(clock), .reset(reset), .req(reqV[2]), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdataV[2]), .ack(ackV[2]), .err(errV[2]), .busy(busyV[2])
  );

  function automatic int waitOf(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 0 : 15;
  endfunction

  function automatic logic isBad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete handshake on instance sel, checked against the bench model.
  task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d);
    respT e;
    int   key;
    int   cyc;
    key   = sel * 1024 + int'(a[9:2]);
    e.err = isBad(a);
    if (w) e.rdata = expRd[sel];
    else if (e.err) e.rdata = 32'd0;
    else e.rdata = modelMem.exists(key) ? modelMem[key] : 32'hxxxxxxxx;
    sb.push_back(e);

    @(negedge clock);
    reqV[sel] = 1'b1;
    wr        = w;
    addr      = a;
    wdata     = d;
    @(posedge clock);
    #1 check($sformatf("busy_after_capture[%0d]", sel), 32'(busyV[sel]), 32'd1);

    cyc = 0;
    while (cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (ackV[sel]) break;
    end
    reqV[sel] = 1'b0;
    check($sformatf("ack_latency[%0d] addr=%h", sel, a), 32'(cyc), 32'(waitOf(sel) + 1));
    e = sb.pop_front();
    check($sformatf("err[%0d] addr=%h", sel, a), 32'(errV[sel]), 32'(e.err));
    check($sformatf("rdata[%0d] addr=%h", sel, a), rdataV[sel], e.rdata);
    if (w && !e.err) modelMem[key] = d;
    if (!w) expRd[sel] = e.rdata;

    @(negedge clock);
    check($sformatf("ack_one_cycle[%0d]", sel), 32'(ackV[sel]), 32'd0);
    check($sformatf("busy_idle[%0d]", sel), 32'(busyV[sel]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reqV  = 3'b000;
    wr    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    for (int i = 0; i < 3; i++) expRd[i] = 32'd0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ack[%0d]", i), 32'(ackV[i]), 32'd0);
      check($sformatf("reset_err[%0d]", i), 32'(errV[i]), 32'd0);
      check($sformatf("reset_busy[%0d]", i), 32'(busyV[i]), 32'd0);
      check($sformatf("reset_rdata[%0d]", i), rdataV[i], 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);

    // Store then load, misaligned load, out-of-range store.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 32'h10, 32'd0);
    access(0, 1'b0, 32'h13, 32'd0);
    access(0, 1'b0, 32'h10, 32'd0);
    access(0, 1'b1, 32'h0, 32'h0BADF00D);
    access(0, 1'b1, 32'h400, 32'hFFFFFFFF);
    access(0, 1'b0, 32'h0, 32'd0);
    access(0, 1'b1, 32'h3FC, 32'h0F0F0F0F);
    access(0, 1'b0, 32'h3FC, 32'd0);

    // Reset in the middle of a store's wait phase drops the store.
    access(0, 1'b1, 32'h20, 32'hCAFEF00D);
    @(negedge clock);
    reqV[0] = 1'b1;
    wr      = 1'b1;
    addr    = 32'h20;
    wdata   = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("busy_async_reset", 32'(busyV[0]), 32'd0);
    check("ack_async_reset", 32'(ackV[0]), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    reqV[0] = 1'b0;
    for (int i = 0; i < 3; i++) expRd[i] = 32'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("no_ack_after_reset[%0d]", k), 32'(ackV[0]), 32'd0);
    end
    access(0, 1'b0, 32'h20, 32'd0);

    // Zero wait states with req held high: ack and busy alternate each cycle.
    access(1, 1'b1, 32'h0, 32'h5A5A5A5A);
    access(1, 1'b0, 32'h0, 32'd0);
    @(negedge clock);
    reqV[1] = 1'b1;
    wr      = 1'b0;
    addr    = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check($sformatf("held_ack[%0d]", k), 32'(ackV[1]), 32'(k % 2));
      check($sformatf("held_busy[%0d]", k), 32'(busyV[1]), 32'(k % 2));
      if (k % 2 == 1) check($sformatf("held_rdata[%0d]", k), rdataV[1], 32'h5A5A5A5A);
    end
    reqV[1] = 1'b0;
    repeat (2) @(negedge clock);
    check("held_busy_end", 32'(busyV[1]), 32'd0);

    // Maximum wait states, top word of the array.
    access(2, 1'b1, 32'h3FC, 32'h13579BDF);
    access(2, 1'b0, 32'h3FC, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
